// File: rtl/unlock_pkg.sv
// Shared definitions for the ASCII unlock interface.
// Holds the transmitter FSM state type, which the detector bench also uses,
// the ASCII character constants and the default unlock code.
// No ports.
package unlock_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } tx_state_t;

   localparam logic [7:0] CH_A    = 8'h41;
   localparam logic [7:0] CH_B    = 8'h42;
   localparam logic [7:0] CH_C    = 8'h43;
   localparam logic [7:0] CH_D    = 8'h44;
   localparam logic [7:0] CH_IDLE = 8'h00;

   // First-sent character sits in the most-significant byte.
   localparam logic [31:0] DEFAULT_CODE_ABCA = {CH_A, CH_B, CH_C, CH_A};

endpackage

// File: rtl/unlock_code_regs.sv
// CODE_LEN x 8 register file holding the unlock code.
// Ports:
//   i_clk      rising-edge clock
//   i_rst      asynchronous active-high reset, reloads DEFAULT_CODE
//   i_wr_en    write strobe, already qualified by the caller (idle only)
//   i_wr_idx   slot to write, 0 = first sent; out-of-range slots are dropped
//   i_wr_char  character to store
//   i_rd_idx   slot to read
//   o_rd_char  combinational read of slot i_rd_idx
module unlock_code_regs
   import unlock_pkg::*;
#(
   parameter int                    CODE_LEN     = 4,
   parameter logic [CODE_LEN*8-1:0] DEFAULT_CODE = DEFAULT_CODE_ABCA,
   parameter int                    IDXW         = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_wr_en,
   input  logic [IDXW-1:0] i_wr_idx,
   input  logic [7:0]      i_wr_char,
   input  logic [IDXW-1:0] i_rd_idx,
   output logic [7:0]      o_rd_char
);

   localparam logic [IDXW:0] LEN = (IDXW+1)'(CODE_LEN);

   logic [7:0] r_code [CODE_LEN];
   logic       w_idx_ok;

   // Zero-extend so the range check also works when CODE_LEN is not a power of two.
   assign w_idx_ok = ({1'b0, i_wr_idx} < LEN);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < CODE_LEN; i++) begin
            r_code[i] <= DEFAULT_CODE[(CODE_LEN-1-i)*8 +: 8];
         end
      end else if (i_wr_en && w_idx_ok) begin
         r_code[i_wr_idx] <= i_wr_char;
      end
   end

   assign o_rd_char = r_code[i_rd_idx];

endmodule

// File: rtl/unlock_code_tx.sv
// Transmit side of the ASCII unlock interface.
// Stores a programmable CODE_LEN-character code and, on start, offers it one
// character per ready/valid transfer. All outputs are registered.
// Optional build macro: UNLOCK_TX_PARITY_EN -- bit 7 of every offered
// character becomes the even parity of bits 6:0.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   wr_en      code write strobe (honoured only when idle)
//   wr_idx     slot to write, 0 = first sent
//   wr_char    character to store
//   start      request to send the stored code (honoured only when idle)
//   ready      sink accepts ascii_out this cycle
//   ascii_out  character on offer, 8'h00 when not valid
//   valid      ascii_out carries a code character
//   busy       sequence in progress (SEND or DONE)
//   done       one-cycle pulse after the last character is accepted
module unlock_code_tx
   import unlock_pkg::*;
#(
   parameter int                    CODE_LEN     = 4,
   parameter logic [CODE_LEN*8-1:0] DEFAULT_CODE = DEFAULT_CODE_ABCA,
   parameter int                    IDXW         = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wr_en,
   input  logic [IDXW-1:0] wr_idx,
   input  logic [7:0]      wr_char,
   input  logic            start,
   input  logic            ready,
   output logic [7:0]      ascii_out,
   output logic            valid,
   output logic            busy,
   output logic            done
);

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CODE_LEN - 1);

   tx_state_t       r_state, w_state_nxt;
   logic [IDXW-1:0] r_idx, w_idx_nxt;
   logic [7:0]      r_ascii, w_ascii_nxt;
   logic            r_valid, w_valid_nxt;
   logic            r_busy, w_busy_nxt;
   logic            r_done, w_done_nxt;
   logic [7:0]      w_rd_char;
   logic            w_wr_ok;

   function automatic logic [7:0] f_out_char(input logic [7:0] c);
`ifdef UNLOCK_TX_PARITY_EN
      return {^c[6:0], c[6:0]};
`else
      return c;
`endif
   endfunction

   // The code is locked while a sequence is running.
   assign w_wr_ok = wr_en && (r_state == IDLE);

   unlock_code_regs #(
      .CODE_LEN     (CODE_LEN),
      .DEFAULT_CODE (DEFAULT_CODE),
      .IDXW         (IDXW)
   ) u_regs (
      .i_clk     (clk),
      .i_rst     (reset),
      .i_wr_en   (w_wr_ok),
      .i_wr_idx  (wr_idx),
      .i_wr_char (wr_char),
      .i_rd_idx  (w_idx_nxt),
      .o_rd_char (w_rd_char)
   );

   // The read mux looks at the next index so the registered ascii_out already
   // shows the following character on the edge of each transfer.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_ascii_nxt = r_ascii;
      w_valid_nxt = r_valid;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_idx_nxt   = '0;
            w_ascii_nxt = CH_IDLE;
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            if (start) begin
               w_state_nxt = SEND;
               w_ascii_nxt = f_out_char(w_rd_char);
               w_valid_nxt = 1'b1;
               w_busy_nxt  = 1'b1;
            end
         end
         SEND: begin
            if (ready) begin
               if (r_idx == LAST_IDX) begin
                  w_state_nxt = DONE;
                  w_idx_nxt   = '0;
                  w_ascii_nxt = CH_IDLE;
                  w_valid_nxt = 1'b0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_idx_nxt   = r_idx + IDXW'(1);
                  w_ascii_nxt = f_out_char(w_rd_char);
               end
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
            w_ascii_nxt = CH_IDLE;
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
         end
         default: begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
            w_ascii_nxt = CH_IDLE;
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_ascii <= CH_IDLE;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_ascii <= w_ascii_nxt;
         r_valid <= w_valid_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign ascii_out = r_ascii;
   assign valid     = r_valid;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule
